// File: rtl/lp_filter_cascade_mc.sv
// Time-multiplexed multi-channel cascade of first-order signed low-pass sections.
// One shared subtract/shift/add datapath walks the stages of the accepted channel.
module lp_filter_cascade_mc #(
  parameter int CHANNELS      = 4,
  parameter int STAGES        = 3,
  parameter int IN_DATA_BITS  = 30,
  parameter int OUT_DATA_BITS = 30,
  parameter int FRAC_BITS     = 8,
  parameter int SHIFT_MAX     = 15,
  localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int SH_BITS = $clog2(SHIFT_MAX + 1)
) (
  input  logic                            CLK,
  input  logic                            RESET_N,
  input  logic                            CE,
  input  logic                            CLEAR,
  input  logic                            IN_VALID,
  output logic                            IN_READY,
  input  logic [CH_BITS-1:0]              IN_CHANNEL,
  input  logic signed [IN_DATA_BITS-1:0]  IN_VALUE,
  input  logic [SH_BITS-1:0]              SHIFT,
  output logic                            OUT_VALID,
  output logic [CH_BITS-1:0]              OUT_CHANNEL,
  output logic signed [OUT_DATA_BITS-1:0] OUT_VALUE
);

  localparam int SW     = IN_DATA_BITS + FRAC_BITS;
  localparam int K_BITS = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [K_BITS-1:0]  K_LAST   = K_BITS'(STAGES - 1);
  localparam logic [CH_BITS:0]   CH_LIMIT = CHANNELS[CH_BITS:0];
  localparam logic [SH_BITS-1:0] SH_LIMIT = SHIFT_MAX[SH_BITS-1:0];

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                          r_state, w_state_next;
  logic [K_BITS-1:0]               r_k;
  logic [CH_BITS-1:0]              r_ch;
  logic [SH_BITS-1:0]              r_sh;
  logic signed [SW-1:0]            r_u;
  logic signed [SW-1:0]            r_s [CHANNELS][STAGES];
  logic [CHANNELS-1:0]             r_primed;
  logic                            r_out_valid;
  logic [CH_BITS-1:0]              r_out_ch;
  logic signed [OUT_DATA_BITS-1:0] r_out_val;

  logic                            w_accept, w_ch_ok;
  logic [SH_BITS-1:0]              w_sh_in;
  logic signed [SW-1:0]            w_s_cur, w_s_new;
  logic signed [SW:0]              w_d, w_d_sh;
  logic signed [IN_DATA_BITS-1:0]  w_fin;
  logic signed [OUT_DATA_BITS-1:0] w_sat;

  assign IN_READY    = (r_state == StIdle);
  assign OUT_VALID   = r_out_valid;
  assign OUT_CHANNEL = r_out_ch;
  assign OUT_VALUE   = r_out_val;

  assign w_accept = CE && IN_VALID && IN_READY && !CLEAR;
  assign w_ch_ok  = ({1'b0, IN_CHANNEL} < CH_LIMIT);
  assign w_sh_in  = (SHIFT > SH_LIMIT) ? SH_LIMIT : SHIFT;

  // r_u holds the stage input: x_ext for stage 0, then each freshly written stage state.
  assign w_s_cur = r_s[r_ch][r_k];
  assign w_d     = {r_u[SW-1], r_u} - {w_s_cur[SW-1], w_s_cur};
  assign w_d_sh  = w_d >>> r_sh;
  assign w_s_new = r_primed[r_ch] ? SW'(w_s_cur + w_d_sh) : r_u;

  assign w_fin = r_s[r_ch][STAGES-1][SW-1:FRAC_BITS];

  if (OUT_DATA_BITS >= IN_DATA_BITS) begin : g_ext
    assign w_sat = OUT_DATA_BITS'(w_fin);
  end else begin : g_sat
    logic w_fits;
    assign w_fits = (w_fin[IN_DATA_BITS-1:OUT_DATA_BITS-1] ==
                     {(IN_DATA_BITS - OUT_DATA_BITS + 1){w_fin[IN_DATA_BITS-1]}});
    assign w_sat  = w_fits ? w_fin[OUT_DATA_BITS-1:0] :
                    w_fin[IN_DATA_BITS-1] ? {1'b1, {(OUT_DATA_BITS - 1){1'b0}}} :
                                            {1'b0, {(OUT_DATA_BITS - 1){1'b1}}};
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_accept && w_ch_ok) w_state_next = StRun;
      StRun:   if (r_k == K_LAST) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    if (CLEAR) w_state_next = StIdle;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= StIdle;
    end else if (CE) begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_k         <= '0;
      r_ch        <= '0;
      r_sh        <= '0;
      r_u         <= '0;
      r_primed    <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_val   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < STAGES; k++) begin
          r_s[c][k] <= '0;
        end
      end
    end else if (CE) begin
      r_out_valid <= (r_state == StDone) && !CLEAR;
      if (CLEAR) begin
        r_primed <= '0;
      end else begin
        case (r_state)
          StIdle: begin
            if (w_accept && w_ch_ok) begin
              r_u  <= {IN_VALUE, {FRAC_BITS{1'b0}}};
              r_ch <= IN_CHANNEL;
              r_sh <= w_sh_in;
              r_k  <= '0;
            end
          end
          StRun: begin
            r_s[r_ch][r_k] <= w_s_new;
            r_u            <= w_s_new;
            r_k            <= r_k + K_BITS'(1);
          end
          StDone: begin
            r_out_ch       <= r_ch;
            r_out_val      <= w_sat;
            r_primed[r_ch] <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lp_filter_cascade_mc.sv
// Bench for lp_filter_cascade_mc: default-parameter instance plus a narrow-output,
// three-channel instance, both checked against an arithmetic reference model.
module tb_lp_filter_cascade_mc;

  localparam int STAGES = 3;
  localparam int FRAC   = 8;

  logic clk = 1'b0;
  logic rst_n, ce, clear;
  always #5 clk = ~clk;

  logic               a_valid, a_ready, a_ov;
  logic [1:0]         a_ch, a_och;
  logic signed [29:0] a_val, a_oval;
  logic [3:0]         a_sh;

  logic               b_valid, b_ready, b_ov;
  logic [1:0]         b_ch, b_och;
  logic signed [29:0] b_val;
  logic signed [15:0] b_oval;
  logic [3:0]         b_sh;

  lp_filter_cascade_mc u_dut (
    .CLK(clk), .RESET_N(rst_n), .CE(ce), .CLEAR(clear),
    .IN_VALID(a_valid), .IN_READY(a_ready), .IN_CHANNEL(a_ch), .IN_VALUE(a_val),
    .SHIFT(a_sh), .OUT_VALID(a_ov), .OUT_CHANNEL(a_och), .OUT_VALUE(a_oval)
  );

  lp_filter_cascade_mc #(
    .CHANNELS(3), .OUT_DATA_BITS(16), .SHIFT_MAX(10)
  ) u_dut_sat (
    .CLK(clk), .RESET_N(rst_n), .CE(ce), .CLEAR(clear),
    .IN_VALID(b_valid), .IN_READY(b_ready), .IN_CHANNEL(b_ch), .IN_VALUE(b_val),
    .SHIFT(b_sh), .OUT_VALID(b_ov), .OUT_CHANNEL(b_och), .OUT_VALUE(b_oval)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: [instance][channel][stage]
  longint m_s  [2][4][3];
  bit     m_pr [2][4];
  int     m_outb  [2] = '{30, 16};
  int     m_shmax [2] = '{15, 10};

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint model_run(input int d, input int ch, input longint v,
                                       input int sh_in);
    longint u, lim;
    int sh;
    sh = (sh_in > m_shmax[d]) ? m_shmax[d] : sh_in;
    u  = v * 256;
    for (int k = 0; k < STAGES; k++) begin
      if (!m_pr[d][ch]) m_s[d][ch][k] = u;
      else              m_s[d][ch][k] = m_s[d][ch][k] + ((u - m_s[d][ch][k]) >>> sh);
      u = m_s[d][ch][k];
    end
    m_pr[d][ch] = 1'b1;
    u   = u >>> FRAC;
    lim = longint'(1) << (m_outb[d] - 1);
    if (u > lim - 1) u = lim - 1;
    if (u < -lim)    u = -lim;
    return u;
  endfunction

  function automatic void model_unprime();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) m_pr[d][c] = 1'b0;
  endfunction

  function automatic void model_reset();
    model_unprime();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < STAGES; k++) m_s[d][c][k] = 0;
  endfunction

  function automatic bit ov(input int d);
    return (d != 0) ? b_ov : a_ov;
  endfunction
  function automatic bit rdy(input int d);
    return (d != 0) ? b_ready : a_ready;
  endfunction
  function automatic longint och(input int d);
    return (d != 0) ? longint'(b_och) : longint'(a_och);
  endfunction
  function automatic longint oval(input int d);
    return (d != 0) ? longint'(b_oval) : longint'(a_oval);
  endfunction

  task automatic drive(input int d, input int ch, input longint v, input int sh, input bit vld);
    if (d != 0) begin
      b_valid = vld; b_ch = 2'(ch); b_val = v[29:0]; b_sh = 4'(sh);
    end else begin
      a_valid = vld; a_ch = 2'(ch); a_val = v[29:0]; a_sh = 4'(sh);
    end
  endtask

  // Send one sample and wait for its result; optionally hold CE low for ce_gap cycles mid-run.
  task automatic send(input int d, input int ch, input longint v, input int sh,
                      input int ce_gap, output longint got);
    int lat;
    bit seen;
    longint exp;
    for (int i = 0; i < 20 && !rdy(d); i++) @(negedge clk);
    check("in_ready_before_send", longint'(rdy(d)), 1);
    drive(d, ch, v, sh, 1'b1);
    @(negedge clk);
    drive(d, 0, 0, 0, 1'b0);
    lat  = 1;
    seen = 1'b0;
    while (lat < 40) begin
      if (ov(d)) begin
        seen = 1'b1;
        break;
      end
      if (ce_gap > 0 && lat == 2)          ce = 1'b0;
      if (ce_gap > 0 && lat == 2 + ce_gap) ce = 1'b1;
      @(negedge clk);
      lat++;
    end
    ce  = 1'b1;
    exp = model_run(d, ch, v, sh);
    check("out_valid_seen", longint'(seen), 1);
    check("latency", lat, STAGES + 2 + ce_gap);
    check("out_channel", och(d), ch);
    check("out_value", oval(d), exp);
    got = oval(d);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_unprime();
  endtask

  function automatic int count_pulses_init();
    return 0;
  endfunction

  initial begin
    longint got, prev, v, held;
    int pulses, rv;

    rst_n = 1'b0; ce = 1'b1; clear = 1'b0;
    drive(0, 0, 0, 0, 1'b0);
    drive(1, 0, 0, 0, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_in_ready", longint'(a_ready), 1);
    check("reset_out_valid", longint'(a_ov), 0);
    check("reset_out_channel", och(0), 0);
    check("reset_out_value", oval(0), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Priming: first sample loads the cascade directly
    send(0, 0, 109377165, 5, 0, got);
    check("prime_passthrough", got, 109377165);

    // Step response with channel isolation on ch1
    pulse_clear();
    send(0, 1, 1000, 5, 0, got);
    send(0, 0, 0, 5, 0, got);
    send(0, 0, 109377165, 5, 0, got);
    check("step_first", got, 3337);
    prev = got;
    for (int i = 0; i < 2999; i++) begin
      if (i < 100) begin
        send(0, 1, 1000, 5, 0, got);
        check("iso_ch1", got, 1000);
      end
      send(0, 0, 109377165, 5, 0, got);
      check("rise_monotonic", longint'(got >= prev), 1);
      prev = got;
    end
    check("rise_settle", longint'(got >= 109377164 && got <= 109377165), 1);
    for (int i = 0; i < 3000; i++) begin
      send(0, 0, -109377165, 5, 0, got);
      check("fall_monotonic", longint'(got <= prev), 1);
      prev = got;
    end
    check("fall_settle", got, -109377165);

    // Shift 0 is pass-through on a primed channel
    send(0, 2, 777, 5, 0, got);
    send(0, 2, 54688582, 0, 0, got);
    check("shift0_passthrough", got, 54688582);

    // Narrow-output instance: saturation and shift clamping
    send(1, 0, 109377165, 5, 0, got);
    check("sat_pos", got, 32767);
    send(1, 1, -109377165, 5, 0, got);
    check("sat_neg", got, -32768);
    send(1, 2, 5000, 5, 0, got);
    send(1, 2, -5000, 15, 0, got);
    held = got;

    // Out-of-range channel is consumed silently
    drive(1, 3, 12345, 5, 1'b1);
    @(negedge clk);
    drive(1, 0, 0, 0, 1'b0);
    check("bad_ch_ready", longint'(b_ready), 1);
    pulses = count_pulses_init();
    repeat (10) begin
      @(negedge clk);
      if (b_ov) pulses++;
    end
    check("bad_ch_no_out", pulses, 0);
    check("bad_ch_value_held", oval(1), held);
    send(1, 2, -5000, 15, 0, got);
    send(1, 0, 109377165, 3, 0, got);

    // Randomized traffic on the default instance
    for (int i = 0; i < 200; i++) begin
      rv = int'($urandom);
      v  = longint'(rv >>> 2);
      send(0, int'($urandom_range(3, 0)), v, int'($urandom_range(15, 0)), 0, got);
    end

    // CE held low mid-run stretches latency only
    rv = int'($urandom);
    send(0, 3, longint'(rv >>> 2), 7, 10, got);

    // CLEAR mid-run aborts and forces repriming
    drive(0, 1, 4242, 5, 1'b1);
    @(negedge clk);
    drive(0, 0, 0, 0, 1'b0);
    @(negedge clk);
    clear = 1'b1;
    pulses = 0;
    @(negedge clk);
    clear = 1'b0;
    model_unprime();
    repeat (10) begin
      if (a_ov) pulses++;
      @(negedge clk);
    end
    check("clear_no_out", pulses, 0);
    send(0, 1, -31415926, 5, 0, got);
    check("clear_reprime", got, -31415926);

    // Reset mid-run zeroes outputs at once
    drive(0, 2, 99999, 5, 1'b1);
    @(negedge clk);
    drive(0, 0, 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", longint'(a_ov), 0);
    check("rst_mid_out_channel", och(0), 0);
    check("rst_mid_out_value", oval(0), 0);
    check("rst_mid_in_ready", longint'(a_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (a_ov) pulses++;
    end
    check("rst_mid_no_out", pulses, 0);
    send(0, 2, 271828, 5, 0, got);
    check("rst_reprime", got, 271828);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
